// File: rtl/uart1_rx.sv
// UART1 serial receiver: 8N1 frames from rx1 rebuilt into bytes with a valid/ack handshake.
// Reports stop-bit framing errors and overruns; bit timing comes from CLKS_PER_BIT.
module uart1_rx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx1,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       overrun,
  output logic       serial_in_active
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [7:0] LAST_CYC = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF_LAST = 8'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  logic       sync1_r;
  logic       rxs_r;
  state_t     state_r, state_s;
  logic [7:0] cyc_r, cyc_s;
  logic [2:0] bit_r, bit_s;
  logic [7:0] shift_r, shift_s;
  logic       commit_s;
  logic       ferr_s;
  logic       ack_s;

  assign ack_s = data_valid & data_ack;

  // Two-flop synchronizer, preset to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= rx1;
      rxs_r   <= sync1_r;
    end
  end

  // Frame state, counters and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cyc_r   <= 8'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
    end else begin
      state_r <= state_s;
      cyc_r   <= cyc_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
    end
  end

  // Next-state logic; counting restarts at the start-bit midpoint so data samples land mid-bit.
  always_comb begin
    state_s  = state_r;
    cyc_s    = cyc_r;
    bit_s    = bit_r;
    shift_s  = shift_r;
    commit_s = 1'b0;
    ferr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rxs_r) begin
          state_s = START;
          cyc_s   = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cyc_r == HALF_LAST) begin
          if (rxs_r) begin
            state_s = IDLE;
          end else begin
            state_s = DATA;
            cyc_s   = 8'd0;
            bit_s   = 3'd0;
          end
        end else begin
          cyc_s = cyc_r + 8'd1;
        end
      end
      DATA: begin
        if (cyc_r == LAST_CYC) begin
          shift_s[bit_r] = rxs_r;
          cyc_s          = 8'd0;
          bit_s          = bit_r + 3'd1;
          if (bit_r == 3'd7) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          cyc_s = cyc_r + 8'd1;
        end
      end
      STOP: begin
        if (cyc_r == LAST_CYC) begin
          cyc_s = 8'd0;
          if (rxs_r) begin
            commit_s = 1'b1;
            state_s  = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = WAIT_HIGH;
          end
        end else begin
          cyc_s = cyc_r + 8'd1;
        end
      end
      WAIT_HIGH: begin
        if (rxs_r) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_HIGH;
        end
      end
      default: begin
        state_s = IDLE;
        cyc_s   = 8'd0;
        bit_s   = 3'd0;
      end
    endcase
  end

  // Output byte handshake; an ack coinciding with a commit frees the slot for the new byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out         <= 8'd0;
      data_valid       <= 1'b0;
      frame_error      <= 1'b0;
      overrun          <= 1'b0;
      serial_in_active <= 1'b0;
    end else begin
      frame_error      <= ferr_s;
      serial_in_active <= (state_s != IDLE);
      if (commit_s && data_valid && !data_ack) begin
        overrun <= 1'b1;
      end else if (commit_s) begin
        data_out   <= shift_r;
        data_valid <= 1'b1;
        if (ack_s) begin
          overrun <= 1'b0;
        end
      end else if (ack_s) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart1_rx.sv
// Self-checking bench for uart1_rx: scenario tasks plus randomized frames against
// a byte-level handshake model.
module tb_uart1_rx;

  localparam int CPB = 8;
  localparam int HALF = CPB / 2;
  localparam int LATENCY = 2 + HALF + 9 * CPB + 1;
  localparam int COMMIT_IDX = LATENCY - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx1;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       overrun;
  logic       serial_in_active;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int fe_count = 0;
  logic prev_dv = 1'b0;

  // Reference model of the consumer-visible state
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ov = 1'b0;

  uart1_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx1(rx1), .data_ack(data_ack),
    .data_out(data_out), .data_valid(data_valid), .frame_error(frame_error),
    .overrun(overrun), .serial_in_active(serial_in_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Record data_valid rises and count frame_error high cycles
  always @(negedge clk) begin
    prev_dv <= data_valid;
    if (data_valid && !prev_dv) rise_cyc <= cyc_cnt;
    if (frame_error) fe_count <= fe_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_frame(input logic [7:0] b);
    if (!exp_valid) begin
      exp_valid = 1'b1;
      exp_data  = b;
    end else begin
      exp_ov = 1'b1;
    end
  endtask

  task automatic model_ack();
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_ov    = 1'b0;
    end
  endtask

  // Drive one frame; data_ack is pulsed on the frame cycle index ack_idx (-1 = never)
  task automatic send_byte(input logic [7:0] b, input logic stop, input int ack_idx);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    start_cyc = cyc_cnt;
    for (int k = 0; k < 10 * CPB; k++) begin
      rx1 = frame[k / CPB];
      data_ack = (k == ack_idx);
      tick();
    end
    data_ack = 1'b0;
  endtask

  task automatic do_ack();
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic bad;
    bad = 1'b0;
    rst = 1'b0; rx1 = 1'b1; data_ack = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if ({data_out, data_valid, frame_error, overrun, serial_in_active} !== 12'h000) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL reset_hold outputs nonzero during reset"); end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({data_out, data_valid, frame_error, overrun, serial_in_active} !== 12'h000) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL reset_idle outputs nonzero after release"); end
  endtask

  task automatic test_single_byte();
    int fe0;
    fe0 = fe_count;
    rise_cyc = -1;
    send_byte(8'h5B, 1'b1, -1);
    model_frame(8'h5B);
    checks++;
    if (rise_cyc - start_cyc !== LATENCY) begin
      errors++; $display("FAIL single_latency got %0d exp %0d", rise_cyc - start_cyc, LATENCY);
    end
    checks++;
    if (data_out !== exp_data || data_valid !== exp_valid) begin
      errors++; $display("FAIL single_data got %h/%b exp %h/%b", data_out, data_valid, exp_data, exp_valid);
    end
    checks++;
    if (fe_count !== fe0) begin errors++; $display("FAIL single_ferr got %0d exp %0d", fe_count - fe0, 0); end
    do_ack();
    model_ack();
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'h5B) begin
      errors++; $display("FAIL single_ack got %h/%b exp 5b/0", data_out, data_valid);
    end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_count;
    rx1 = 1'b0;
    tick(); tick();
    rx1 = 1'b1;
    repeat (20) tick();
    checks++;
    if (data_valid !== 1'b0 || overrun !== 1'b0 || serial_in_active !== 1'b0 || fe_count !== fe0) begin
      errors++; $display("FAIL glitch got dv=%b ov=%b act=%b fe=%0d exp 0/0/0/0",
                         data_valid, overrun, serial_in_active, fe_count - fe0);
    end
  endtask

  task automatic test_frame_error();
    int fe0;
    logic dropped;
    fe0 = fe_count;
    dropped = 1'b0;
    send_byte(8'hA5, 1'b0, -1);
    checks++;
    if (fe_count - fe0 !== 1) begin errors++; $display("FAIL ferr_pulse got %0d cycles exp 1", fe_count - fe0); end
    checks++;
    if (data_valid !== 1'b0 || data_out !== exp_data) begin
      errors++; $display("FAIL ferr_data got %h/%b exp %h/0", data_out, data_valid, exp_data);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (serial_in_active !== 1'b1) dropped = 1'b1;
    end
    rx1 = 1'b1;
    tick();
    if (serial_in_active !== 1'b1) dropped = 1'b1;
    checks++;
    if (dropped) begin errors++; $display("FAIL ferr_active got 0 exp 1 while line low"); end
    repeat (4) tick();
    checks++;
    if (serial_in_active !== 1'b0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL ferr_recover got act=%b dv=%b exp 0/0", serial_in_active, data_valid);
    end
  endtask

  task automatic test_overrun();
    send_byte(8'h11, 1'b1, -1); model_frame(8'h11);
    send_byte(8'h22, 1'b1, -1); model_frame(8'h22);
    checks++;
    if (data_out !== exp_data || overrun !== exp_ov || data_valid !== exp_valid) begin
      errors++; $display("FAIL overrun_set got %h/%b/%b exp %h/%b/%b",
                         data_out, data_valid, overrun, exp_data, exp_valid, exp_ov);
    end
    do_ack(); model_ack();
    checks++;
    if (overrun !== 1'b0 || data_valid !== 1'b0 || data_out !== 8'h11) begin
      errors++; $display("FAIL overrun_clear got %h/%b/%b exp 11/0/0", data_out, data_valid, overrun);
    end
  endtask

  task automatic test_ack_collision();
    send_byte(8'h33, 1'b1, -1); model_frame(8'h33);
    send_byte(8'h44, 1'b1, COMMIT_IDX); model_ack(); model_frame(8'h44);
    checks++;
    if (data_out !== 8'h44 || data_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL collision got %h/%b/%b exp 44/1/0", data_out, data_valid, overrun);
    end
  endtask

  task automatic test_midframe_reset();
    logic [9:0] frame;
    frame = {1'b1, 8'h96, 1'b0};
    for (int k = 0; k < 5 * CPB + HALF; k++) begin
      rx1 = frame[k / CPB];
      tick();
    end
    rst = 1'b0;
    #1;
    exp_data = 8'h00; exp_valid = 1'b0; exp_ov = 1'b0;
    checks++;
    if ({data_out, data_valid, frame_error, overrun, serial_in_active} !== 12'h000) begin
      errors++; $display("FAIL midreset got %h/%b/%b/%b/%b exp all 0",
                         data_out, data_valid, frame_error, overrun, serial_in_active);
    end
    repeat (3) tick();
    rx1 = 1'b1;
    rst = 1'b1;
    tick();
    send_byte(8'hC3, 1'b1, -1); model_frame(8'hC3);
    checks++;
    if (data_out !== exp_data || data_valid !== exp_valid) begin
      errors++; $display("FAIL after_reset got %h/%b exp %h/%b", data_out, data_valid, exp_data, exp_valid);
    end
    do_ack(); model_ack();
  endtask

  task automatic test_back_to_back();
    send_byte(8'h01, 1'b1, -1); model_frame(8'h01);
    checks++;
    if (data_out !== exp_data || data_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first got %h/%b exp %h/1", data_out, data_valid, exp_data);
    end
    send_byte(8'hFE, 1'b1, 5); model_ack(); model_frame(8'hFE);
    checks++;
    if (data_out !== exp_data || data_valid !== exp_valid || overrun !== exp_ov) begin
      errors++; $display("FAIL b2b_second got %h/%b/%b exp %h/%b/%b",
                         data_out, data_valid, overrun, exp_data, exp_valid, exp_ov);
    end
    do_ack(); model_ack();
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack got %b exp 0", data_valid); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1, -1);
      model_frame(b);
      checks++;
      if (data_out !== exp_data || data_valid !== exp_valid || overrun !== exp_ov) begin
        errors++; $display("FAIL rand_frame%0d got %h/%b/%b exp %h/%b/%b", i,
                           data_out, data_valid, overrun, exp_data, exp_valid, exp_ov);
      end
      if ($urandom_range(0, 1) == 1) begin
        do_ack(); model_ack();
        checks++;
        if (data_valid !== exp_valid || overrun !== exp_ov || data_out !== exp_data) begin
          errors++; $display("FAIL rand_ack%0d got %h/%b/%b exp %h/%b/%b", i,
                             data_out, data_valid, overrun, exp_data, exp_valid, exp_ov);
        end
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_ack_collision();
    test_midframe_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart1_rx.md
Name: uart1_rx

Overview:
- Serial receiver for the UART1 link; consumes the transmitter's tx1 line and rebuilds parallel bytes.
- Frame format: 1 start bit (low), 8 data bits sent LSB first, 1 stop bit (high). No parity. Line idles high.
- Output is a byte register with a valid/ack handshake to the downstream consumer. Also reports framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 8: clk cycles per serial bit. Legal values are 2 to 255; the value must be even.
- HALF_BIT, CLKS_PER_BIT/2: derived parameter, not overridden. Sets the mid-bit sample offset.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, asynchronous assert, active-low.
- rx1  input  1  serial line from the UART1 transmitter; idles high.
- data_ack  input  1  consumer accepts data_out; sampled only while data_valid=1.
- data_out  output  8  last correctly received byte.
- data_valid  output  1  data_out holds an unconsumed byte.
- frame_error  output  1  one-cycle pulse when the stop bit samples low.
- overrun  output  1  sticky flag: a byte was lost because data_valid was still 1.
- serial_in_active  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - data_out=0, data_valid=0, frame_error=0, overrun=0, serial_in_active=0.
  - State = IDLE, bit counter = 0, cycle counter = 0.
  - Both synchronizer flops are preset to 1.
  - Reset can arrive mid-frame. It aborts the frame and the partial byte is discarded.
- Input sync: rx1 passes through a 2-flop synchronizer to give rxs. All decisions use rxs, so there are 2 cycles of input latency.
- State machine: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rxs=0, go to START and set cyc=0.
  - START: cyc increments each cycle. At cyc=HALF_BIT-1, sample rxs.
    - rxs=1: glitch. Go to IDLE with no flags raised.
    - rxs=0: set cyc=0, bit=0, go to DATA.
  - DATA: when cyc=CLKS_PER_BIT-1, shift rxs into shift[bit], increment bit and set cyc=0. After bit 7 is sampled, go to STOP.
    - These samples fall at mid-bit because the counting started at the start-bit midpoint.
  - STOP: sample rxs at cyc=CLKS_PER_BIT-1.
    - rxs=1: commit the byte (see below). Go to IDLE.
    - rxs=0: pulse frame_error for 1 cycle. Do not change data_out or data_valid. Go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. A break or stuck-low line never starts a new frame.
- Commit, in the cycle after the stop sample:
  - If data_valid=0: load data_out with the shift register and set data_valid=1.
  - If data_valid=1 and data_ack is not 1 in that same cycle: keep the old data_out, drop the new byte, set overrun=1.
  - If data_valid=1 and data_ack=1 in that same cycle: the ack wins. Load the new byte, data_valid stays 1, no overrun.
- Handshake:
  - data_valid stays 1 until the cycle after data_ack=1 is sampled with data_valid=1. At that point data_valid drops to 0 (unless the simultaneous commit rule applies).
  - data_out holds its value after the ack.
  - data_ack while data_valid=0 is ignored.
- overrun is sticky. It clears only on reset or on the first data_ack after it was set.
- Back-to-back frames: the receiver returns to IDLE during the stop bit. The next falling edge is accepted immediately, so zero extra idle cycles are needed.
- Latency: the rx1 start-bit falling edge to data_valid rise is 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles, which is 79 for the default.

Test Plan:
- Idle and reset: rst=0 at time 0, rx1=1, hold 50 cycles, then release reset. Required: all outputs 0 and serial_in_active=0 throughout.
- Single byte: send 0x5B (line bits 1,1,0,1,1,0,1,0 after the start bit), no ack. Required: data_valid rises exactly 79 cycles after the start edge, data_out=0x5B, frame_error=0. Then ack: data_valid=0 the next cycle and data_out stays 0x5B.
- Glitch and framing:
  - Drive a 2-cycle low pulse on idle rx1. Required: return to IDLE with no flags.
  - Send a frame with the stop bit low (byte 0xA5). Required: frame_error is a single-cycle pulse, data_valid stays 0, serial_in_active stays 1 until rx1 returns high.
- Overrun: send 0x11, no ack, then send 0x22. Required: data_out=0x11 and overrun=1. Ack: overrun=0 and data_valid=0.
- Ack collision: hold data_valid with 0x33 and assert data_ack in the exact commit cycle of 0x44. Required: data_out=0x44, data_valid=1, overrun=0.
- Mid-frame reset, then back-to-back frames:
  - Assert rst during data bit 4. Required: immediate return to reset values. A subsequent frame 0xC3 is received correctly.
  - Send 0x01 then 0xFE with no idle gap and ack each one. Required: both bytes are received correctly.
